uop_tribus_ctrl: RTL

//  Controller/reader for a shared tri-state bus driven by N enable-gated drivers (wire outputs, 'z when en low).
//  - Arbitrates round-robin among requesting drivers; issues one-hot enables.
//  - Samples the bus into a registered output with valid/source tags.
//  - Inserts turnaround cycles between drivers so two drivers never overlap.

---
 rtl/uop_tribus_ctrl_if.sv | 26 ++
 rtl/uop_tribus_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uop_tribus_ctrl_if.sv
// Signal bundle between the tri-state bus controller and the bus drivers / consumer.
// master: controller side; slave: drivers and consumer side.
interface uop_tribus_ctrl_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic             rdy;
  wire  [W-1:0]     bus;
  logic [N-1:0]     en;
  logic [W-1:0]     dout;
  logic             dvalid;
  logic [IDX_W-1:0] dsrc;

  modport master (
    input  req, rdy, bus,
    output en, dout, dvalid, dsrc
  );

  modport slave (
    output req, rdy, bus,
    input  en, dout, dvalid, dsrc
  );
endinterface

// File: rtl/uop_tribus_ctrl.sv
// Round-robin controller/reader for a shared tri-state bus with turnaround gaps.
// Define UOP_TRIBUS_BURST_EN to allow up to MBURST consecutive beats per grant.
module uop_tribus_ctrl #(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int TURN   = 1,
  parameter int MBURST = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  uop_tribus_ctrl_if.master     bif
);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int TCNT_W = (TURN > 1) ? $clog2(TURN) : 1;

  if (N < 2 || TURN < 1 || MBURST < 1) begin : g_param_err
    $error("uop_tribus_ctrl: requires N>=2, TURN>=1, MBURST>=1");
  end

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

  state_t            state_q,  state_d;
  logic [IDX_W-1:0]  ptr_q,    ptr_d;
  logic [N-1:0]      en_q,     en_d;
  logic [W-1:0]      dout_q,   dout_d;
  logic              dvalid_q, dvalid_d;
  logic [IDX_W-1:0]  dsrc_q,   dsrc_d;
  logic [TCNT_W-1:0] tcnt_q,   tcnt_d;
`ifdef UOP_TRIBUS_BURST_EN
  localparam int BCNT_W = $clog2(MBURST + 1);
  logic [BCNT_W-1:0] beat_q,   beat_d;
`endif

  // First requester strictly after p, wrapping modulo N.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    pick = p;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(p) + k) % N);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    en_d     = en_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    dsrc_d   = dsrc_q;
    tcnt_d   = tcnt_q;
`ifdef UOP_TRIBUS_BURST_EN
    beat_d   = beat_q;
`endif
    case (state_q)
      S_IDLE: begin
        en_d = '0;
        if ((|bif.req) && bif.rdy) begin
          // ptr_q doubles as the selected driver for the whole grant.
          ptr_d   = rr_pick(bif.req, ptr_q);
          en_d    = onehot(ptr_d);
          state_d = S_DRIVE;
`ifdef UOP_TRIBUS_BURST_EN
          beat_d  = '0;
`endif
        end
      end
      S_DRIVE: begin
        if (bif.req[ptr_q] && bif.rdy) begin
          dout_d   = bif.bus;
          dsrc_d   = ptr_q;
          dvalid_d = 1'b1;
`ifdef UOP_TRIBUS_BURST_EN
          beat_d   = beat_q + 1'b1;
          if (int'(beat_q) + 1 >= MBURST) begin
            en_d    = '0;
            tcnt_d  = TCNT_W'(TURN - 1);
            state_d = S_TURN;
          end
`else
          en_d    = '0;
          tcnt_d  = TCNT_W'(TURN - 1);
          state_d = S_TURN;
`endif
        end else begin
          // Requester withdrew or consumer stalled: end of transfer.
          en_d    = '0;
          tcnt_d  = TCNT_W'(TURN - 1);
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        en_d = '0;
        if (tcnt_q == '0) state_d = S_IDLE;
        else              tcnt_d  = tcnt_q - 1'b1;
      end
      default: begin
        en_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDX_W'(N - 1);
      en_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      dsrc_q   <= '0;
      tcnt_q   <= '0;
`ifdef UOP_TRIBUS_BURST_EN
      beat_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      en_q     <= en_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      dsrc_q   <= dsrc_d;
      tcnt_q   <= tcnt_d;
`ifdef UOP_TRIBUS_BURST_EN
      beat_q   <= beat_d;
`endif
    end
  end

  assign bif.en     = en_q;
  assign bif.dout   = dout_q;
  assign bif.dvalid = dvalid_q;
  assign bif.dsrc   = dsrc_q;
endmodule
